// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the fetch-stage state encoding.
package pipe_pkg;

    // Bubble word and reset PC as seen by the decode stage.
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    // Opcode field (instr[15:11]) values the fetch side cares about.
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    // FETCH: request outstanding; BUF: word parked behind a stall;
    // DROP: discarding a response made stale by a redirect; HALTED: idle until reset.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        BUF    = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline latch: flush (insert bubble) beats load, otherwise hold.
module if_id_reg #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc2_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc2_out,
    output logic               valid_out
);

    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [PC_W-1:0]    pc2_d,   pc2_q;
    logic               valid_d, valid_q;

    // Select next latch contents: bubble, new entry, or hold.
    always_comb begin
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc2_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc2_d   = pc2_in;
            valid_d = 1'b1;
        end
    end

    // Latch update; reset presents a bubble to decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc2_out   = pc2_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction fetch: PC, multicycle imem handshake, one-entry skid buffer,
// redirect/halt handling, feeding the IF/ID latch.
module fetch_if_id #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(pipe_pkg::RESET_PC),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_done,
    input  logic               stall_id,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_id,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc2,
    output logic               if_id_valid,
    output logic               fetch_busy
);

    import pipe_pkg::*;

    fetch_state_e       state_d, state_q;
    logic [PC_W-1:0]    pc_d, pc_q;
    logic [INSTR_W-1:0] buf_instr_d, buf_instr_q;
    logic [PC_W-1:0]    buf_pc2_d, buf_pc2_q;

    logic               ifid_load;
    logic               ifid_flush;
    logic [INSTR_W-1:0] ifid_instr_in;
    logic [PC_W-1:0]    ifid_pc2_in;
    logic [PC_W-1:0]    pc_inc;

    // Sequential PC advance; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_plus2(input logic [PC_W-1:0] pc);
        return pc + PC_W'(2);
    endfunction

    assign pc_inc = pc_plus2(pc_q);

    // Next-state, PC, skid buffer and IF/ID control; redirect beats halt beats normal flow.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc2_d     = buf_pc2_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_instr_in = imem_rdata;
        ifid_pc2_in   = pc_inc;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                    // A response still in flight must be swallowed before refetching.
                    state_d    = imem_done ? FETCH : DROP;
                end else if (halt_id) begin
                    ifid_flush = 1'b1;
                    state_d    = HALTED;
                end else if (imem_done) begin
                    pc_d = pc_inc;
                    if (stall_id) begin
                        buf_instr_d = imem_rdata;
                        buf_pc2_d   = pc_inc;
                        state_d     = BUF;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (!stall_id) begin
                    ifid_flush = 1'b1;
                end
            end

            BUF: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                    state_d    = FETCH;
                end else if (halt_id) begin
                    ifid_flush = 1'b1;
                    state_d    = HALTED;
                end else if (!stall_id) begin
                    ifid_load     = 1'b1;
                    ifid_instr_in = buf_instr_q;
                    ifid_pc2_in   = buf_pc2_q;
                    state_d       = FETCH;
                end
            end

            DROP: begin
                if (redirect) begin
                    // Later redirect only retargets; the stale access is still pending.
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                    state_d    = imem_done ? FETCH : DROP;
                end else if (halt_id) begin
                    ifid_flush = 1'b1;
                    state_d    = HALTED;
                end else begin
                    if (!stall_id) begin
                        ifid_flush = 1'b1;
                    end
                    if (imem_done) begin
                        state_d = FETCH;
                    end
                end
            end

            HALTED: begin
                state_d = HALTED;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Control state: FSM and PC, reset to a fresh fetch at RESET_PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Skid buffer payload; only meaningful while in BUF, so no reset.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc2_q   <= buf_pc2_d;
    end

    if_id_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .instr_in  (ifid_instr_in),
        .pc2_in    (ifid_pc2_in),
        .instr_out (if_id_instr),
        .pc2_out   (if_id_pc2),
        .valid_out (if_id_valid)
    );

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q != FETCH);

endmodule

// File: doc/fetch_if_id.md
Name: fetch_if_id

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Sits directly upstream of the decode/control block.
- Owns the PC and drives a multicycle instruction-memory handshake.
- Delivers the instruction word, PC+2 and a valid flag to decode. The valid flag drives the decoder's Valid_PC input; instruction bits [15:11]/[1:0] feed Opcode/Mode.
- Handles decode stalls (one-entry skid buffer), EX-stage redirects (flush plus in-flight discard) and HALT.

Parameters:
- PC_W, 16, PC and memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value after reset
- NOP_INSTR, 16'h0800, bubble word (opcode 00001, NOP)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request; held high with a stable imem_addr until imem_done
- imem_addr  out  PC_W  fetch address
- imem_rdata  in  INSTR_W  instruction word; valid only in the cycle imem_done=1
- imem_done  in  1  access complete; may arrive in the same cycle imem_req rises or later
- stall_id  in  1  hazard unit: hold the IF/ID contents
- redirect  in  1  taken branch/jump/RTI resolved in EX
- redirect_pc  in  PC_W  new PC target when redirect=1
- halt_id  in  1  decode's Halt output (already qualified by Valid_PC)
- if_id_instr  out  INSTR_W  instruction to decode
- if_id_pc2  out  PC_W  PC+2 of that instruction
- if_id_valid  out  1  instruction is real (not a bubble)
- fetch_busy  out  1  high while the state is not FETCH

Behaviour:
- Reset (rst_n=0 at an edge): state=FETCH, pc=RESET_PC, buffer empty, if_id_instr=NOP_INSTR, if_id_pc2=0, if_id_valid=0. imem_req=1 from the first cycle after reset.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - BUF: fetched word parked; imem_req=0.
  - DROP: discarding an in-flight response; imem_req=0.
  - HALTED: imem_req=0 permanently until reset.
- FETCH, imem_done=1, stall_id=0:
  - IF/ID <= {imem_rdata, pc+2, valid=1}; pc <= pc+2.
  - Stay in FETCH. Back-to-back single-cycle memory gives one instruction per cycle.
- FETCH, imem_done=1, stall_id=1:
  - IF/ID holds its contents.
  - buffer <= {imem_rdata, pc+2}; pc <= pc+2; go to BUF.
- FETCH, imem_done=0: IF/ID holds if stall_id=1. Otherwise IF/ID <= bubble (valid=0, NOP_INSTR).
- BUF, stall_id=0: IF/ID <= buffer with valid=1; buffer empties; go to FETCH. No memory access occurs during BUF.
- Redirect (any state except HALTED) has highest priority:
  - pc <= redirect_pc; buffer discarded; IF/ID <= bubble, regardless of stall_id.
  - If a request is outstanding (FETCH with imem_done=0 this cycle), go to DROP. Otherwise go to FETCH.
  - If imem_done=1 in the same cycle, that word is discarded and the state goes to FETCH.
- DROP: wait for imem_done, discard imem_rdata, go to FETCH with the redirected pc. A second redirect in DROP only updates pc.
- HALT:
  - halt_id=1 with redirect=0: IF/ID <= bubble, buffer discarded, go to HALTED.
  - An outstanding request's imem_done is ignored; the memory must still complete it.
  - If redirect=1 in the same cycle, the redirect wins (it comes from an older instruction) and HALT is ignored.
- Arithmetic: pc+2 is modulo 2^PC_W; 16'hFFFE wraps to 16'h0000.
- stall_id with redirect=0 never changes IF/ID contents.
- Reset mid-access: the state returns to FETCH. The memory is required to abort on reset, so no DROP is needed.

Decomposition:
- Shared package pipe_pkg: NOP_INSTR, RESET_PC, opcode constants (HALT=5'b00000, NOP=5'b00001), fetch state enum {FETCH, BUF, DROP, HALTED}.
- One natural sub-module: if_id_reg. It is the IF/ID register with load, hold and flush controls, reused for other pipeline latches.
- The PC, FSM and skid buffer stay in fetch_if_id.

Test Plan:
- Reset, then single-cycle memory returning 0x4001, 0x4002, 0x4003 at addresses 0, 2, 4 → if_id_valid=1 from cycle 2; if_id_pc2 = 2, 4, 6 on consecutive cycles.
- stall_id=1 for 3 cycles while imem_done=1 for 0x4002 → IF/ID holds 0x4001; BUF entered with imem_req=0. On stall release, IF/ID=0x4002 with pc2=4; the next request is to address 4.
- Memory with 3-cycle latency, redirect to 0x0100 in the second wait cycle → DROP. The late word is discarded; next imem_addr=0x0100; IF/ID shows a bubble (0x0800, valid=0) throughout.
- halt_id=1 → imem_req falls next cycle and stays 0; IF/ID=bubble. Redirect plus halt_id in the same cycle → fetch continues at redirect_pc.
- pc=0xFFFE, done=1 → if_id_pc2=0x0000; next imem_addr=0x0000.
- rst_n=0 while in DROP → next cycle state=FETCH, imem_addr=RESET_PC, if_id_valid=0.
